mc_control_unit: RTL and testbench
==================================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset; forces state sIF immediately.
REQ-003 opcode  in  6  IR[31:26], held stable by the IR register from sID onward.
REQ-004 zero  in  1  ALU result == 0, valid in sEXE_BR.
REQ-005 sign  in  1  ALU result[31], valid in sEXE_BR.
REQ-006 mem_ready  in  1  data memory done; sampled only in sMEM.
REQ-007 PCWre  out  1  PC load enable; the IF stage loads PC on the edge ending a cycle where PCWre=1.
REQ-008 PCSrc  out  2  next-PC select: 00 PC+4, 01 PC+4+(imm<<2), 10 rs (jr), 11 jump target.
REQ-009 IRWre  out  1  IR load enable.
REQ-010 RegWre  out  1  register file write enable.
REQ-011 RegDst  out  2  write register: 00 $31, 01 rt, 10 rd.
REQ-012 WrRegDSrc  out  1  write data: 0 PC+4 (jal), 1 DB bus.
REQ-013 DBDataSrc  out  1  DB source: 0 ALU result, 1 data memory.
REQ-014 ALUSrcA, ALUSrcB, ExtSel  out  1 each  sa/rs select, imm/rt select, sign/zero extend.
REQ-015 ALUOp  out  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt.
REQ-016 mRD, mWR  out  1 each  data memory read / write strobes.
REQ-017 state  out  3  current state, for debug.

Function
REQ-018 States and encoding: sIF=000, sID=001, sEXE_AL=010, sWB_AL=011, sEXE_BR=100, sEXE_LS=101, sMEM=110, sWB_LD=111; HALT shares sID's decode path and is held in a separate 1-bit halted register.
REQ-019 Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111.
REQ-020 Outputs are Moore/Mealy combinational from state, opcode, zero, sign and mem_ready; every output not named active in a state is 0.
REQ-021 sIF: IRWre=1 -> sID unconditionally.
REQ-022 sID routing:
- j/jr: PCWre=1, PCSrc=11/10 -> sIF.
- jal: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0 -> sIF.
- beq/bne/bltz -> sEXE_BR.
- lw/sw -> sEXE_LS.
- other listed ALU opcodes -> sEXE_AL.
- halt: set halted, PCWre=0.
- unlisted opcode: PCWre=1, PCSrc=00 -> sIF (nop).
REQ-023 sEXE_AL: ALUOp per opcode; ALUSrcB=1 for addi/ori; ExtSel=1 for addi only; ALUSrcA=1 for sll -> sWB_AL.
REQ-024 sWB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0, RegDst=01 for I-type else 10; PCWre=1, PCSrc=00 -> sIF.
REQ-025 sEXE_BR: ALUOp=001, ExtSel=1, PCWre=1; PCSrc=01 when taken (beq: zero=1; bne: zero=0; bltz: sign=1), else 00 -> sIF.
REQ-026 sEXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1 -> sMEM.
REQ-027 sMEM: mRD=1 (lw) or mWR=1 (sw), held while mem_ready=0 and state stays sMEM. On mem_ready=1: sw asserts PCWre=1, PCSrc=00 -> sIF; lw -> sWB_LD.
REQ-028 sWB_LD: RegWre=1, WrRegDSrc=1, DBDataSrc=1, RegDst=01, PCWre=1, PCSrc=00 -> sIF.
REQ-029 Halted: state frozen at sID, all enables (PCWre, IRWre, RegWre, mRD, mWR) 0 until rst.
REQ-030 Cycle counts per instruction: j/jr/jal 2; beq/bne/bltz 3; ALU 4; sw 4+wait; lw 5+wait.
REQ-031 PCWre is 1 in exactly one cycle per completed instruction.

Reset
REQ-032 rst=1 asynchronously sets state=sIF and halted=0; outputs immediately decode to sIF (IRWre=1, all other outputs 0).
REQ-033 Reset mid-instruction (including a sMEM wait) abandons it; no RegWre/mWR pulse is issued after rst rises.

Verification
REQ-034 Reset, add (000000): states IF,ID,EXE_AL,WB_AL,IF; RegWre=1 and PCWre=1 only in WB_AL; RegDst=10.
REQ-035 beq with zero=1 -> PCSrc=01 in EXE_BR; with zero=0 -> PCSrc=00; bltz with sign=1 -> PCSrc=01; 3 cycles each.
REQ-036 lw with mem_ready held 0 for 3 cycles: mRD=1 for 4 cycles in sMEM, then WB_LD with DBDataSrc=1, RegDst=01.
REQ-037 jal: in sID PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0; next state sIF.
REQ-038 halt: state sticks at 001, PCWre=IRWre=0 for 10+ cycles; rst pulse returns to sIF.
REQ-039 rst asserted between edges during sMEM (sw): state=000 before next edge, mWR=0 immediately.

Source files
------------

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS-subset control unit: an 8-state Moore/Mealy sequencer with a sticky halt flag.
// All control outputs decode combinationally from the current state, the opcode and the ALU/memory flags.
module mc_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       sign,
    input  logic       mem_ready,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       IRWre,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       DBDataSrc,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic [2:0] ALUOp,
    output logic       mRD,
    output logic       mWR,
    output logic [2:0] state
);

    localparam int unsigned OPW = 6;

    localparam logic [OPW-1:0] OP_ADD  = 6'b000000;
    localparam logic [OPW-1:0] OP_SUB  = 6'b000001;
    localparam logic [OPW-1:0] OP_ADDI = 6'b000010;
    localparam logic [OPW-1:0] OP_OR   = 6'b010000;
    localparam logic [OPW-1:0] OP_AND  = 6'b010001;
    localparam logic [OPW-1:0] OP_ORI  = 6'b010010;
    localparam logic [OPW-1:0] OP_SLL  = 6'b011000;
    localparam logic [OPW-1:0] OP_SLT  = 6'b100110;
    localparam logic [OPW-1:0] OP_SW   = 6'b110000;
    localparam logic [OPW-1:0] OP_LW   = 6'b110001;
    localparam logic [OPW-1:0] OP_BEQ  = 6'b110100;
    localparam logic [OPW-1:0] OP_BNE  = 6'b110101;
    localparam logic [OPW-1:0] OP_BLTZ = 6'b110110;
    localparam logic [OPW-1:0] OP_J    = 6'b111000;
    localparam logic [OPW-1:0] OP_JR   = 6'b111001;
    localparam logic [OPW-1:0] OP_JAL  = 6'b111010;
    localparam logic [OPW-1:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_AL = 3'b010,
        S_WB_AL  = 3'b011,
        S_EXE_BR = 3'b100,
        S_EXE_LS = 3'b101,
        S_MEM    = 3'b110,
        S_WB_LD  = 3'b111
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_halted;
    logic   w_set_halt;
    logic   w_is_itype;

    // State and halt flag; halt is only cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IF;
            r_halted <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign state      = r_state;
    assign w_is_itype = (opcode == OP_ADDI) || (opcode == OP_ORI);

    // Next-state and control decode.
    always_comb begin
        w_next     = r_state;
        w_set_halt = 1'b0;
        PCWre      = 1'b0;
        PCSrc      = 2'b00;
        IRWre      = 1'b0;
        RegWre     = 1'b0;
        RegDst     = 2'b00;
        WrRegDSrc  = 1'b0;
        DBDataSrc  = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 1'b0;
        ExtSel     = 1'b0;
        ALUOp      = 3'b000;
        mRD        = 1'b0;
        mWR        = 1'b0;

        case (r_state)
            S_IF: begin
                IRWre  = 1'b1;
                w_next = S_ID;
            end

            S_ID: begin
                if (r_halted) begin
                    w_next = S_ID;
                end else begin
                    case (opcode)
                        OP_J: begin
                            PCWre  = 1'b1;
                            PCSrc  = 2'b11;
                            w_next = S_IF;
                        end
                        OP_JR: begin
                            PCWre  = 1'b1;
                            PCSrc  = 2'b10;
                            w_next = S_IF;
                        end
                        OP_JAL: begin
                            PCWre  = 1'b1;
                            PCSrc  = 2'b11;
                            RegWre = 1'b1;
                            RegDst = 2'b00;
                            w_next = S_IF;
                        end
                        OP_BEQ, OP_BNE, OP_BLTZ: w_next = S_EXE_BR;
                        OP_LW, OP_SW:            w_next = S_EXE_LS;
                        OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT:
                            w_next = S_EXE_AL;
                        OP_HALT: begin
                            w_set_halt = 1'b1;
                            w_next     = S_ID;
                        end
                        default: begin
                            // Unknown opcodes retire as a two-cycle nop.
                            PCWre  = 1'b1;
                            PCSrc  = 2'b00;
                            w_next = S_IF;
                        end
                    endcase
                end
            end

            S_EXE_AL: begin
                case (opcode)
                    OP_SUB: ALUOp = 3'b001;
                    OP_ADDI: begin
                        ALUOp   = 3'b000;
                        ALUSrcB = 1'b1;
                        ExtSel  = 1'b1;
                    end
                    OP_OR:  ALUOp = 3'b011;
                    OP_AND: ALUOp = 3'b100;
                    OP_ORI: begin
                        ALUOp   = 3'b011;
                        ALUSrcB = 1'b1;
                    end
                    OP_SLL: begin
                        ALUOp   = 3'b010;
                        ALUSrcA = 1'b1;
                    end
                    OP_SLT:  ALUOp = 3'b101;
                    default: ALUOp = 3'b000;
                endcase
                w_next = S_WB_AL;
            end

            S_WB_AL: begin
                RegWre    = 1'b1;
                WrRegDSrc = 1'b1;
                DBDataSrc = 1'b0;
                RegDst    = w_is_itype ? 2'b01 : 2'b10;
                PCWre     = 1'b1;
                PCSrc     = 2'b00;
                w_next    = S_IF;
            end

            S_EXE_BR: begin
                ALUOp  = 3'b001;
                ExtSel = 1'b1;
                PCWre  = 1'b1;
                if (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero) ||
                    ((opcode == OP_BLTZ) && sign)) begin
                    PCSrc = 2'b01;
                end
                w_next = S_IF;
            end

            S_EXE_LS: begin
                ALUOp   = 3'b000;
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                w_next  = S_MEM;
            end

            S_MEM: begin
                mRD = (opcode == OP_LW);
                mWR = (opcode == OP_SW);
                // Strobes stay up until the memory acknowledges.
                if (mem_ready) begin
                    if (opcode == OP_LW) begin
                        w_next = S_WB_LD;
                    end else begin
                        PCWre  = (opcode == OP_SW);
                        w_next = S_IF;
                    end
                end
            end

            S_WB_LD: begin
                RegWre    = 1'b1;
                WrRegDSrc = 1'b1;
                DBDataSrc = 1'b1;
                RegDst    = 2'b01;
                PCWre     = 1'b1;
                PCSrc     = 2'b00;
                w_next    = S_IF;
            end

            default: w_next = S_IF;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks each instruction class cycle by cycle
// and compares state plus the packed control word against hand-derived values.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic       zero = 1'b0;
    logic       sign = 1'b0;
    logic       mem_ready = 1'b0;

    logic       PCWre, IRWre, RegWre, WrRegDSrc, DBDataSrc;
    logic       ALUSrcA, ALUSrcB, ExtSel, mRD, mWR;
    logic [1:0] PCSrc, RegDst;
    logic [2:0] ALUOp, state;

    int n_tests = 0;
    int n_fail  = 0;

    // Packed view: PCWre_PCSrc_IRWre_RegWre_RegDst_WrRegDSrc_DBDataSrc_ALUSrcA_ALUSrcB_ExtSel_ALUOp_mRD_mWR
    wire [16:0] outs = {PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc, DBDataSrc,
                        ALUSrcA, ALUSrcB, ExtSel, ALUOp, mRD, mWR};

    localparam logic [16:0] O_IF    = 17'b0_00_1_0_00_0_0_0_0_0_000_0_0;
    localparam logic [16:0] O_Z     = 17'b0_00_0_0_00_0_0_0_0_0_000_0_0;
    localparam logic [16:0] O_WB_R  = 17'b1_00_0_1_10_1_0_0_0_0_000_0_0;
    localparam logic [16:0] O_WB_I  = 17'b1_00_0_1_01_1_0_0_0_0_000_0_0;
    localparam logic [16:0] O_LS    = 17'b0_00_0_0_00_0_0_0_1_1_000_0_0;
    localparam logic [16:0] O_WBLD  = 17'b1_00_0_1_01_1_1_0_0_0_000_0_0;
    localparam logic [16:0] O_NOP   = 17'b1_00_0_0_00_0_0_0_0_0_000_0_0;
    localparam logic [16:0] O_BR_T  = 17'b1_01_0_0_00_0_0_0_0_1_001_0_0;
    localparam logic [16:0] O_BR_N  = 17'b1_00_0_0_00_0_0_0_0_1_001_0_0;
    localparam logic [16:0] O_JAL   = 17'b1_11_0_1_00_0_0_0_0_0_000_0_0;
    localparam logic [16:0] O_J     = 17'b1_11_0_0_00_0_0_0_0_0_000_0_0;
    localparam logic [16:0] O_JR    = 17'b1_10_0_0_00_0_0_0_0_0_000_0_0;
    localparam logic [16:0] O_RD    = 17'b0_00_0_0_00_0_0_0_0_0_000_1_0;
    localparam logic [16:0] O_WR    = 17'b0_00_0_0_00_0_0_0_0_0_000_0_1;
    localparam logic [16:0] O_WR_OK = 17'b1_00_0_0_00_0_0_0_0_0_000_0_1;

    mc_control_unit dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .sign      (sign),
        .mem_ready (mem_ready),
        .PCWre     (PCWre),
        .PCSrc     (PCSrc),
        .IRWre     (IRWre),
        .RegWre    (RegWre),
        .RegDst    (RegDst),
        .WrRegDSrc (WrRegDSrc),
        .DBDataSrc (DBDataSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ExtSel    (ExtSel),
        .ALUOp     (ALUOp),
        .mRD       (mRD),
        .mWR       (mWR),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({state, outs} !== {3'd0, O_IF}) begin
            n_fail++;
            $display("FAIL reset_async: state=%0d outs=%b, expected state=0 outs=%b", state, outs, O_IF);
        end
        tick();
        n_tests++;
        if ({state, outs} !== {3'd0, O_IF}) begin
            n_fail++;
            $display("FAIL reset_held: state=%0d outs=%b, expected state=0 outs=%b", state, outs, O_IF);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu;
        logic [5:0]  ops [8];
        logic [16:0] exe [8];
        logic [16:0] wb  [8];
        ops[0] = 6'b000000; exe[0] = 17'b0_00_0_0_00_0_0_0_0_0_000_0_0; wb[0] = O_WB_R;
        ops[1] = 6'b000001; exe[1] = 17'b0_00_0_0_00_0_0_0_0_0_001_0_0; wb[1] = O_WB_R;
        ops[2] = 6'b000010; exe[2] = 17'b0_00_0_0_00_0_0_0_1_1_000_0_0; wb[2] = O_WB_I;
        ops[3] = 6'b010000; exe[3] = 17'b0_00_0_0_00_0_0_0_0_0_011_0_0; wb[3] = O_WB_R;
        ops[4] = 6'b010001; exe[4] = 17'b0_00_0_0_00_0_0_0_0_0_100_0_0; wb[4] = O_WB_R;
        ops[5] = 6'b010010; exe[5] = 17'b0_00_0_0_00_0_0_0_1_0_011_0_0; wb[5] = O_WB_I;
        ops[6] = 6'b011000; exe[6] = 17'b0_00_0_0_00_0_0_1_0_0_010_0_0; wb[6] = O_WB_R;
        ops[7] = 6'b100110; exe[7] = 17'b0_00_0_0_00_0_0_0_0_0_101_0_0; wb[7] = O_WB_R;
        for (int i = 0; i < 8; i++) begin
            opcode = ops[i];
            n_tests++;
            if ({state, outs} !== {3'd0, O_IF}) begin
                n_fail++;
                $display("FAIL alu%0d_if: state=%0d outs=%b, expected state=0 outs=%b", i, state, outs, O_IF);
            end
            tick();
            n_tests++;
            if ({state, outs} !== {3'd1, O_Z}) begin
                n_fail++;
                $display("FAIL alu%0d_id: state=%0d outs=%b, expected state=1 outs=%b", i, state, outs, O_Z);
            end
            tick();
            n_tests++;
            if ({state, outs} !== {3'd2, exe[i]}) begin
                n_fail++;
                $display("FAIL alu%0d_exe: state=%0d outs=%b, expected state=2 outs=%b", i, state, outs, exe[i]);
            end
            tick();
            n_tests++;
            if ({state, outs} !== {3'd3, wb[i]}) begin
                n_fail++;
                $display("FAIL alu%0d_wb: state=%0d outs=%b, expected state=3 outs=%b", i, state, outs, wb[i]);
            end
            tick();
        end
    endtask

    task automatic test_branch;
        logic [5:0]  ops [6];
        logic        zs  [6];
        logic        ss  [6];
        logic [16:0] exp [6];
        ops[0] = 6'b110100; zs[0] = 1'b1; ss[0] = 1'b0; exp[0] = O_BR_T;
        ops[1] = 6'b110100; zs[1] = 1'b0; ss[1] = 1'b0; exp[1] = O_BR_N;
        ops[2] = 6'b110101; zs[2] = 1'b0; ss[2] = 1'b0; exp[2] = O_BR_T;
        ops[3] = 6'b110101; zs[3] = 1'b1; ss[3] = 1'b0; exp[3] = O_BR_N;
        ops[4] = 6'b110110; zs[4] = 1'b0; ss[4] = 1'b1; exp[4] = O_BR_T;
        ops[5] = 6'b110110; zs[5] = 1'b1; ss[5] = 1'b0; exp[5] = O_BR_N;
        for (int i = 0; i < 6; i++) begin
            opcode = ops[i];
            zero   = zs[i];
            sign   = ss[i];
            tick();
            n_tests++;
            if ({state, outs} !== {3'd1, O_Z}) begin
                n_fail++;
                $display("FAIL br%0d_id: state=%0d outs=%b, expected state=1 outs=%b", i, state, outs, O_Z);
            end
            tick();
            n_tests++;
            if ({state, outs} !== {3'd4, exp[i]}) begin
                n_fail++;
                $display("FAIL br%0d_exe: state=%0d outs=%b, expected state=4 outs=%b", i, state, outs, exp[i]);
            end
            tick();
            n_tests++;
            if ({state, outs} !== {3'd0, O_IF}) begin
                n_fail++;
                $display("FAIL br%0d_done: state=%0d outs=%b, expected state=0 outs=%b", i, state, outs, O_IF);
            end
        end
        zero = 1'b0;
        sign = 1'b0;
    endtask

    task automatic test_jump;
        logic [5:0]  ops [5];
        logic [16:0] exp [5];
        ops[0] = 6'b111010; exp[0] = O_JAL;
        ops[1] = 6'b111000; exp[1] = O_J;
        ops[2] = 6'b111001; exp[2] = O_JR;
        ops[3] = 6'b000011; exp[3] = O_NOP;
        ops[4] = 6'b101010; exp[4] = O_NOP;
        for (int i = 0; i < 5; i++) begin
            opcode = ops[i];
            tick();
            n_tests++;
            if ({state, outs} !== {3'd1, exp[i]}) begin
                n_fail++;
                $display("FAIL jmp%0d_id: state=%0d outs=%b, expected state=1 outs=%b", i, state, outs, exp[i]);
            end
            tick();
            n_tests++;
            if ({state, outs} !== {3'd0, O_IF}) begin
                n_fail++;
                $display("FAIL jmp%0d_done: state=%0d outs=%b, expected state=0 outs=%b", i, state, outs, O_IF);
            end
        end
    endtask

    task automatic test_lw_wait;
        opcode    = 6'b110001;
        mem_ready = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({state, outs} !== {3'd5, O_LS}) begin
            n_fail++;
            $display("FAIL lw_exe: state=%0d outs=%b, expected state=5 outs=%b", state, outs, O_LS);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) mem_ready = 1'b1;
            #1;
            n_tests++;
            if ({state, outs} !== {3'd6, O_RD}) begin
                n_fail++;
                $display("FAIL lw_mem%0d: state=%0d outs=%b, expected state=6 outs=%b", i, state, outs, O_RD);
            end
        end
        tick();
        mem_ready = 1'b0;
        n_tests++;
        if ({state, outs} !== {3'd7, O_WBLD}) begin
            n_fail++;
            $display("FAIL lw_wb: state=%0d outs=%b, expected state=7 outs=%b", state, outs, O_WBLD);
        end
        tick();
        n_tests++;
        if ({state, outs} !== {3'd0, O_IF}) begin
            n_fail++;
            $display("FAIL lw_done: state=%0d outs=%b, expected state=0 outs=%b", state, outs, O_IF);
        end
    endtask

    task automatic test_sw_wait;
        opcode    = 6'b110000;
        mem_ready = 1'b0;
        tick();
        tick();
        tick();
        n_tests++;
        if ({state, outs} !== {3'd6, O_WR}) begin
            n_fail++;
            $display("FAIL sw_wait: state=%0d outs=%b, expected state=6 outs=%b", state, outs, O_WR);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        n_tests++;
        if ({state, outs} !== {3'd6, O_WR_OK}) begin
            n_fail++;
            $display("FAIL sw_ready: state=%0d outs=%b, expected state=6 outs=%b", state, outs, O_WR_OK);
        end
        tick();
        mem_ready = 1'b0;
        n_tests++;
        if ({state, outs} !== {3'd0, O_IF}) begin
            n_fail++;
            $display("FAIL sw_done: state=%0d outs=%b, expected state=0 outs=%b", state, outs, O_IF);
        end
    endtask

    task automatic test_halt;
        opcode = 6'b111111;
        tick();
        n_tests++;
        if ({state, outs} !== {3'd1, O_Z}) begin
            n_fail++;
            $display("FAIL halt_id: state=%0d outs=%b, expected state=1 outs=%b", state, outs, O_Z);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            // Late cycles swap the opcode to prove the halt flag, not the opcode, holds the freeze.
            if (i >= 8) opcode = 6'b000000;
            #1;
            n_tests++;
            if ({state, outs} !== {3'd1, O_Z}) begin
                n_fail++;
                $display("FAIL halt_hold%0d: state=%0d outs=%b, expected state=1 outs=%b", i, state, outs, O_Z);
            end
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({state, outs} !== {3'd0, O_IF}) begin
            n_fail++;
            $display("FAIL halt_rst: state=%0d outs=%b, expected state=0 outs=%b", state, outs, O_IF);
        end
        tick();
        rst = 1'b0;
        opcode = 6'b111000;
        tick();
        n_tests++;
        if ({state, outs} !== {3'd1, O_J}) begin
            n_fail++;
            $display("FAIL halt_recover: state=%0d outs=%b, expected state=1 outs=%b", state, outs, O_J);
        end
        tick();
    endtask

    task automatic test_reset_in_mem;
        opcode    = 6'b110000;
        mem_ready = 1'b0;
        tick();
        tick();
        tick();
        n_tests++;
        if ({state, outs} !== {3'd6, O_WR}) begin
            n_fail++;
            $display("FAIL rstmem_pre: state=%0d outs=%b, expected state=6 outs=%b", state, outs, O_WR);
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({state, outs} !== {3'd0, O_IF}) begin
            n_fail++;
            $display("FAIL rstmem_async: state=%0d outs=%b, expected state=0 outs=%b", state, outs, O_IF);
        end
        mem_ready = 1'b1;
        tick();
        n_tests++;
        if ({state, outs} !== {3'd0, O_IF}) begin
            n_fail++;
            $display("FAIL rstmem_held: state=%0d outs=%b, expected state=0 outs=%b", state, outs, O_IF);
        end
        mem_ready = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [2:0]  es [7];
        logic [16:0] eo [7];
        es[0] = 3'd0; eo[0] = O_IF;
        es[1] = 3'd1; eo[1] = O_JAL;
        es[2] = 3'd0; eo[2] = O_IF;
        es[3] = 3'd1; eo[3] = O_Z;
        es[4] = 3'd5; eo[4] = O_LS;
        es[5] = 3'd6; eo[5] = O_WR_OK;
        es[6] = 3'd0; eo[6] = O_IF;
        opcode    = 6'b111010;
        mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) opcode = 6'b110000;
            n_tests++;
            if ({state, outs} !== {es[i], eo[i]}) begin
                n_fail++;
                $display("FAIL b2b%0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, outs, es[i], eo[i]);
            end
            if (i < 6) tick();
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_jump();
        test_lw_wait();
        test_sw_wait();
        test_halt();
        test_reset_in_mem();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
